// File: rtl/herald_host.sv
// Host-side initiator for the Herald byte-wide command bus: serialises one request with WR strobes,
// waits on BUSY, then collects the result with RD strobes. Optional wait watchdog: HERALD_HOST_TIMEOUT_EN.
module herald_host #(
  parameter int STROBE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [23:0] req_a,
  input  logic [23:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [71:0] rsp_data,
  output logic [3:0]  rsp_len,
  output logic        rsp_err,
  output logic [7:0]  bus_data_out,
  output logic        bus_wr,
  output logic        bus_rd,
  input  logic [7:0]  bus_data_in
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > STROBE_CYCLES) ? TIMEOUT_CYCLES : STROBE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_HI, S_WR_LO, S_WAIT_BUSY_HI, S_WAIT_DONE, S_RD_HI, S_RD_LO, S_RESP
  } state_t;

  // {known, write byte count, read byte count}
  function automatic logic [7:0] plan_of(input logic [7:0] cmd);
    case (cmd)
      8'h22:                      plan_of = {1'b1, 3'd1, 4'd0};
      8'h10:                      plan_of = {1'b1, 3'd4, 4'd6};
      8'h23:                      plan_of = {1'b1, 3'd4, 4'd3};
      8'h11, 8'h12, 8'h20, 8'h21: plan_of = {1'b1, 3'd7, 4'd3};
      8'h13:                      plan_of = {1'b1, 3'd7, 4'd9};
      default:                    plan_of = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [2:0] idx, input logic [7:0] cmd,
                                          input logic [23:0] a, input logic [23:0] b);
    case (idx)
      3'd0:    byte_sel = cmd;
      3'd1:    byte_sel = a[7:0];
      3'd2:    byte_sel = a[15:8];
      3'd3:    byte_sel = a[23:16];
      3'd4:    byte_sel = b[7:0];
      3'd5:    byte_sel = b[15:8];
      3'd6:    byte_sel = b[23:16];
      default: byte_sel = 8'h00;
    endcase
  endfunction

  state_t        state_r, state_nx;
  logic [CW-1:0] cnt_r;
  logic [7:0]    cmd_r;
  logic [23:0]   a_r, b_r;
  logic [2:0]    wr_len_r, wr_idx_r;
  logic [3:0]    rd_len_r, rd_idx_r;
  logic [1:0]    cap_pipe_r;
  logic          busy_seen_r;
  logic          req_ready_r, rsp_valid_r, rsp_err_r;
  logic [71:0]   rsp_data_r;
  logic [7:0]    bus_data_out_r;
  logic          bus_wr_r, bus_rd_r;

  logic [7:0]    plan_s;
  logic          accept_s, strobe_done_s, busy_s, tmo_s, tmo_hit_s, wr_load_s;
  logic [3:0]    rd_cnt_after_s;

  assign plan_s         = plan_of(req_cmd);
  assign accept_s       = (state_r == S_IDLE) && req_valid && req_ready_r;
  assign strobe_done_s  = (cnt_r == CW'(STROBE_CYCLES - 1));
  assign busy_s         = bus_data_in[7];
  assign rd_cnt_after_s = rd_idx_r + {3'b000, cap_pipe_r[1]};
  assign wr_load_s      = (state_nx == S_WR_HI) && (state_r != S_WR_HI);
`ifdef HERALD_HOST_TIMEOUT_EN
  assign tmo_s          = (cnt_r == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_s          = 1'b0;
`endif

  // next-state decode; a wait that runs out of budget goes straight to RESP
  always_comb begin
    state_nx  = state_r;
    tmo_hit_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nx = plan_s[7] ? S_WR_HI : S_RESP;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WR_HI: begin
        if (strobe_done_s) state_nx = S_WR_LO;
        else               state_nx = S_WR_HI;
      end
      S_WR_LO: begin
        if (!strobe_done_s)              state_nx = S_WR_LO;
        else if (wr_idx_r == 3'd1)       state_nx = S_WAIT_BUSY_HI;
        else if (wr_idx_r == wr_len_r)   state_nx = S_WAIT_DONE;
        else                             state_nx = S_WR_HI;
      end
      S_WAIT_BUSY_HI: begin
        // BUSY may pulse while the command strobe is still in flight, so it is latched
        if (busy_s || busy_seen_r) begin
          state_nx = (wr_idx_r == wr_len_r) ? S_WAIT_DONE : S_WR_HI;
        end else if (tmo_s) begin
          state_nx  = S_RESP;
          tmo_hit_s = 1'b1;
        end else begin
          state_nx = S_WAIT_BUSY_HI;
        end
      end
      S_WAIT_DONE: begin
        if (!busy_s) begin
          state_nx = (rd_len_r == 4'd0) ? S_RESP : S_RD_HI;
        end else if (tmo_s) begin
          state_nx  = S_RESP;
          tmo_hit_s = 1'b1;
        end else begin
          state_nx = S_WAIT_DONE;
        end
      end
      S_RD_HI: begin
        if (strobe_done_s) state_nx = S_RD_LO;
        else               state_nx = S_RD_HI;
      end
      S_RD_LO: begin
        // low phase is stretched while a capture for this strobe is still pending
        if (strobe_done_s && !cap_pipe_r[0]) begin
          state_nx = (rd_cnt_after_s == rd_len_r) ? S_RESP : S_RD_HI;
        end else begin
          state_nx = S_RD_LO;
        end
      end
      S_RESP: begin
        if (rsp_valid_r && rsp_ready) state_nx = S_IDLE;
        else                          state_nx = S_RESP;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // state register and per-state cycle counter (cleared on every state change)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nx;
      if (state_nx != state_r) cnt_r <= {CW{1'b0}};
      else                     cnt_r <= cnt_r + CW'(1);
    end
  end

  // registered handshake, strobes and the RD-to-capture delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      bus_wr_r    <= 1'b0;
      bus_rd_r    <= 1'b0;
      cap_pipe_r  <= 2'b00;
    end else begin
      req_ready_r <= (state_nx == S_IDLE);
      rsp_valid_r <= (state_r == S_RESP) && (state_nx == S_RESP);
      bus_wr_r    <= (state_nx == S_WR_HI);
      bus_rd_r    <= (state_nx == S_RD_HI);
      cap_pipe_r  <= {cap_pipe_r[0], (state_nx == S_RD_HI) && (state_r != S_RD_HI)};
    end
  end

  // request capture, write byte sequencing and response assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r          <= 8'h00;
      a_r            <= 24'h000000;
      b_r            <= 24'h000000;
      wr_len_r       <= 3'd0;
      rd_len_r       <= 4'd0;
      wr_idx_r       <= 3'd0;
      rd_idx_r       <= 4'd0;
      busy_seen_r    <= 1'b0;
      rsp_err_r      <= 1'b0;
      rsp_data_r     <= 72'h0;
      bus_data_out_r <= 8'h00;
    end else if (accept_s) begin
      cmd_r       <= req_cmd;
      a_r         <= req_a;
      b_r         <= req_b;
      wr_len_r    <= plan_s[6:4];
      rd_len_r    <= plan_s[3:0];
      rd_idx_r    <= 4'd0;
      busy_seen_r <= 1'b0;
      rsp_err_r   <= !plan_s[7];
      rsp_data_r  <= 72'h0;
      if (plan_s[7]) begin
        bus_data_out_r <= req_cmd;
        wr_idx_r       <= 3'd1;
      end else begin
        wr_idx_r       <= 3'd0;
      end
    end else begin
      if (wr_load_s) begin
        bus_data_out_r <= byte_sel(wr_idx_r, cmd_r, a_r, b_r);
        wr_idx_r       <= wr_idx_r + 3'd1;
      end
      if ((state_r == S_WR_HI || state_r == S_WR_LO || state_r == S_WAIT_BUSY_HI) &&
          (wr_idx_r == 3'd1) && busy_s) begin
        busy_seen_r <= 1'b1;
      end
      if (tmo_hit_s) begin
        rsp_err_r  <= 1'b1;
        rsp_data_r <= 72'h0;
        rd_idx_r   <= 4'd0;
      end else if (cap_pipe_r[1]) begin
        rsp_data_r[{rd_idx_r, 3'b000} +: 8] <= bus_data_in;
        rd_idx_r                            <= rd_idx_r + 4'd1;
      end
    end
  end

  assign req_ready    = req_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_len      = rd_idx_r;
  assign rsp_err      = rsp_err_r;
  assign bus_data_out = bus_data_out_r;
  assign bus_wr       = bus_wr_r;
  assign bus_rd       = bus_rd_r;

endmodule

// File: tb/tb_herald_host.sv
// Self-checking bench for herald_host: accelerator responder, bus monitor and a transaction-level model.
module tb_herald_host;
  localparam int STROBE = 2;
`ifdef HERALD_HOST_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd = 8'h00;
  logic [23:0] req_a = 24'h0, req_b = 24'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [71:0] rsp_data;
  logic [3:0]  rsp_len;
  logic        rsp_err;
  logic [7:0]  bus_data_out;
  logic        bus_wr, bus_rd;
  logic [7:0]  bus_data_in = 8'h00;

  always #5 clk = ~clk;

  herald_host #(.STROBE_CYCLES(STROBE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_len(rsp_len), .rsp_err(rsp_err),
    .bus_data_out(bus_data_out), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_data_in(bus_data_in)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // responder configuration, written only by the stimulus process
  logic [71:0] cfg_result = 72'h0;
  int          cfg_nwr = 0;
  bit          cfg_stuck = 1'b0;
  int          txn_id = 0;

  // accelerator model: BUSY two cycles after the command strobe, read byte valid for one cycle only
  int   r_ncyc = 0, r_seen = 0, r_rx = 0, r_rd = 0;
  int   r_busy_on = 1 << 30, r_busy_off = 1 << 30;
  logic r_wr_q = 1'b0, r_rd_q = 1'b0, r_pend = 1'b0;
  always @(negedge clk) begin
    r_ncyc++;
    if (r_seen != txn_id || !rst_n) begin
      r_seen = txn_id; r_rx = 0; r_rd = 0; r_pend = 1'b0;
      r_wr_q = 1'b0; r_rd_q = 1'b0;
      r_busy_on = 1 << 30; r_busy_off = 1 << 30;
      bus_data_in = 8'h00;
    end else begin
      if (bus_wr && !r_wr_q) begin
        if (r_rx == 0) begin
          r_busy_on  = r_ncyc + 2;
          r_busy_off = (bus_data_out == 8'h22) ? r_ncyc + 4 : 1 << 30;
        end
        r_rx++;
        if (r_rx == cfg_nwr && r_rx > 1 && !cfg_stuck) r_busy_off = r_ncyc + 6;
      end
      if (r_pend) begin
        bus_data_in = (r_rd < 9) ? cfg_result[8*r_rd +: 8] : 8'h00;
        r_rd++;
        r_pend = 1'b0;
      end else begin
        bus_data_in = {(r_ncyc >= r_busy_on && r_ncyc < r_busy_off), 7'b0000000};
      end
      if (bus_rd && !r_rd_q) r_pend = 1'b1;
      r_wr_q = bus_wr;
      r_rd_q = bus_rd;
    end
  end

  // per-cycle bus monitor: strobe exclusivity, width, data stability; logs every written byte
  logic [7:0] wr_log[$];
  int         rd_strobes = 0;
  int         hi_run = 0;
  time        last_wr_fall = 0;
  logic       m_wr_q = 1'b0, m_rd_q = 1'b0;
  logic [7:0] m_dout_q = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_wr_q = 1'b0; m_rd_q = 1'b0; hi_run = 0; m_dout_q = bus_data_out;
    end else begin
      chk("wr_rd_exclusive", 72'(bus_wr & bus_rd), 72'h0);
      if (rsp_valid || req_ready) chk("strobes_low_idle", 72'({bus_wr, bus_rd}), 72'h0);
      if (bus_wr && !m_wr_q) wr_log.push_back(bus_data_out);
      else chk("dout_stable", 72'(bus_data_out), 72'(m_dout_q));
      if (bus_rd && !m_rd_q) rd_strobes++;
      if (bus_wr || bus_rd) begin
        hi_run++;
      end else if (m_wr_q || m_rd_q) begin
        chk("strobe_width", 72'(hi_run), 72'(STROBE));
        hi_run = 0;
        if (m_wr_q) last_wr_fall = $time;
      end
      m_wr_q = bus_wr; m_rd_q = bus_rd; m_dout_q = bus_data_out;
    end
  end

  // transaction-level model: write bytes and read count from the command table
  function automatic void plan(input logic [7:0] cmd, output int nwr, output int nrd, output bit known);
    known = 1'b1;
    case (cmd)
      8'h22:                      begin nwr = 1; nrd = 0; end
      8'h10:                      begin nwr = 4; nrd = 6; end
      8'h23:                      begin nwr = 4; nrd = 3; end
      8'h11, 8'h12, 8'h20, 8'h21: begin nwr = 7; nrd = 3; end
      8'h13:                      begin nwr = 7; nrd = 9; end
      default:                    begin nwr = 0; nrd = 0; known = 1'b0; end
    endcase
  endfunction

  task automatic run_txn(input string tag, input logic [7:0] cmd, input logic [23:0] a, input logic [23:0] b,
                         input logic [71:0] result, input bit stuck,
                         output logic [71:0] got_data, output logic [55:0] got_wr);
    int nwr, nrd, n, cyc, wbase, rbase;
    bit known;
    logic [7:0]  exp_bytes[7];
    logic [71:0] exp_data;
    time t_rsp;
    plan(cmd, nwr, nrd, known);
    exp_bytes = '{cmd, a[7:0], a[15:8], a[23:16], b[7:0], b[15:8], b[23:16]};
    exp_data = 72'h0;
    for (int i = 0; i < nrd; i++) exp_data[8*i +: 8] = result[8*i +: 8];
    txn_id++; cfg_result = result; cfg_nwr = nwr; cfg_stuck = stuck;
    @(negedge clk);
    wbase = wr_log.size(); rbase = rd_strobes;
    req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_immediate_accept"}, 72'(n), 72'h0);
    @(negedge clk);
    req_valid = 1'b0; req_cmd = 8'hxx; req_a = 24'hxxxxxx; req_b = 24'hxxxxxx;
    chk({tag, "_wr_after_accept"}, 72'(bus_wr), 72'(known));
    cyc = 1;
    while (!rsp_valid && cyc < 3000) begin @(negedge clk); cyc++; end
    t_rsp = $time;
    chk({tag, "_rsp_valid"}, 72'(rsp_valid), 72'h1);
    if (!known) chk({tag, "_err_latency"}, 72'(cyc), 72'd2);
    if (stuck) begin
      chk({tag, "_tmo_err"}, 72'(rsp_err), 72'h1);
      chk({tag, "_tmo_len"}, 72'(rsp_len), 72'h0);
      chk({tag, "_tmo_data"}, rsp_data, 72'h0);
      chk({tag, "_tmo_cycles"}, 72'((t_rsp - last_wr_fall) / 10), 72'(TMO + 3));
    end else begin
      chk({tag, "_rsp_err"}, 72'(rsp_err), 72'(!known));
      chk({tag, "_rsp_len"}, 72'(rsp_len), 72'(nrd));
      chk({tag, "_rsp_data"}, rsp_data, exp_data);
      chk({tag, "_rd_strobes"}, 72'(rd_strobes - rbase), 72'(nrd));
    end
    got_data = rsp_data;
    @(negedge clk);
    chk({tag, "_rsp_held"}, 72'(rsp_valid), 72'h1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, 72'(rsp_valid), 72'h0);
    chk({tag, "_back_idle"}, 72'(req_ready), 72'h1);
    chk({tag, "_wr_count"}, 72'(wr_log.size() - wbase), 72'(nwr));
    got_wr = 56'h0;
    for (int i = 0; i < nwr && (wbase + i) < wr_log.size(); i++) begin
      chk({tag, "_wr_byte"}, 72'(wr_log[wbase + i]), 72'(exp_bytes[i]));
      got_wr = {got_wr[47:0], wr_log[wbase + i]};
    end
  endtask

  initial begin
    logic [71:0] d;
    logic [55:0] w;
    int n;
    #3;
    chk("reset_outputs", 72'({req_ready, rsp_valid, rsp_len, rsp_err, bus_data_out, bus_wr, bus_rd}), 72'h0);
    chk("reset_rsp_data", rsp_data, 72'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 72'(req_ready), 72'h1);

    run_txn("mul", 8'h20, 24'h001000, 24'h002000, 72'h0000000000AA002000, 1'b0, d, w);
    chk("mul_wr_literal", 72'(w), 72'h20001000002000);
    chk("mul_data_literal", d, 72'h000000000000002000);

    run_txn("sincos", 8'h10, 24'h000C91, 24'hABCDEF, 72'h77665500_0FFF000001, 1'b0, d, w);
    chk("sincos_wr_literal", 72'(w), 72'h10910C00);
    chk("sincos_data_literal", d, 72'h000000000FFF000001);

    run_txn("norm", 8'h13, 24'h800001, 24'hFF7F80, 72'h0123456789ABCDEF11, 1'b0, d, w);
    chk("norm_data_literal", d, 72'h0123456789ABCDEF11);

    run_txn("clear", 8'h22, 24'h123456, 24'h654321, 72'h0, 1'b0, d, w);
    run_txn("mac", 8'h21, 24'hFFFFFF, 24'h000001, 72'h0000000000_00C0FFEE, 1'b0, d, w);
    run_txn("atan2", 8'h11, 24'h003000, 24'hFFD000, 72'h00000000000080F0E1, 1'b0, d, w);
    run_txn("msu", 8'h23, 24'h0A0B0C, 24'h0, 72'h000000000000FEDCBA, 1'b0, d, w);
    run_txn("unknown", 8'h55, 24'h111111, 24'h222222, 72'h0, 1'b0, d, w);
    run_txn("sqrt", 8'h12, 24'h004000, 24'h0, 72'h000000000000002000, 1'b0, d, w);
`ifdef HERALD_HOST_TIMEOUT_EN
    run_txn("timeout", 8'h23, 24'h000001, 24'h0, 72'h0, 1'b1, d, w);
`endif

    // reset in the middle of a read phase
    txn_id++; cfg_result = 72'hFFEEDDCCBBAA998877; cfg_nwr = 7; cfg_stuck = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 8'h13; req_a = 24'h1; req_b = 24'h2;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!bus_rd && n < 500) begin @(negedge clk); n++; end
    chk("midread_rd_seen", 72'(bus_rd), 72'h1);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 72'({req_ready, rsp_valid, rsp_len, rsp_err, bus_data_out, bus_wr, bus_rd}), 72'h0);
    chk("async_reset_data", rsp_data, 72'h0);
    txn_id++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midread_reset", 72'(req_ready), 72'h1);
    chk("no_partial_rsp", 72'(rsp_valid), 72'h0);
    run_txn("post_reset", 8'h21, 24'h000100, 24'h000200, 72'h000000000000030201, 1'b0, d, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/herald_host.md
# herald_host

Host-side initiator for the Herald byte-wide command bus. Accepts one coprocessor request (command plus up to two 24-bit Q12.12 operands) on a valid/ready port. It serialises the request onto the 8-bit data bus with WR strobes, waits for BUSY to clear, then pulls the 3/6/9-byte result with RD strobes. It drives the Herald accelerator's `ui_in` / `uio_in[1:0]` and watches its `uo_out`, letting an on-chip sequencer or testbench master issue CORDIC/MAC operations without bit-banging.

## Interface
- `STROBE_CYCLES`, default 2: cycles each WR/RD strobe is held high and then low; minimum 1.
- `TIMEOUT_CYCLES`, default 4096: watchdog limit per wait state; only used with `HERALD_HOST_TIMEOUT_EN`.
- `clk`  in  1  single clock, shared with the accelerator.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_cmd`  in  8  command code: 0x10 SINCOS, 0x11 ATAN2, 0x12 SQRT, 0x13 NORMALIZE, 0x20 MULTIPLY, 0x21 MAC, 0x22 CLEAR, 0x23 MSU.
- `req_a`, `req_b`  in  24 each  operands, captured on accept.
- `rsp_valid`  out  1  response held until `rsp_ready`.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  72  result, byte 0 in [7:0]; unread bytes are 0.
- `rsp_len`  out  4  result bytes read: 0, 3, 6 or 9.
- `rsp_err`  out  1  unknown command or timeout.
- `bus_data_out`  out  8  to accelerator `ui_in`.
- `bus_wr`  out  1  to `uio_in[0]`.
- `bus_rd`  out  1  to `uio_in[1]`.
- `bus_data_in`  in  8  from `uo_out`; bit 7 is BUSY outside read phase.

## Operation
- Reset values: all outputs 0, except `req_ready` = 1 once out of reset. Reset at any point abandons the transaction and drops both strobes. No partial response is issued.
- Accept: when `req_valid && req_ready`, latch cmd/a/b and build the byte plan.
- Byte plan (write bytes / read bytes):
  - CLEAR: cmd / 0.
  - SINCOS: cmd,A0..A2 / 6.
  - MSU: cmd,A0..A2 / 3.
  - ATAN2, SQRT, MULTIPLY, MAC: cmd,A0..A2,B0..B2 / 3.
  - NORMALIZE: cmd,A0..A2,B0..B2 / 9.
  - Operand bytes are sent LSB first.
- Unknown cmd: no bus activity. Go straight to RESP with `rsp_err` = 1 and `rsp_len` = 0.
- States:
  - IDLE: wait for accept.
  - WR_HI: `bus_data_out` = current byte, `bus_wr` = 1 for `STROBE_CYCLES`.
  - WR_LO: `bus_wr` = 0 for `STROBE_CYCLES`, data held.
  - After the command byte, go to WAIT_BUSY_HI: wait until `bus_data_in[7]` = 1, then continue to the next byte.
  - After the last write byte, go to WAIT_DONE.
  - WAIT_DONE: wait until `bus_data_in[7]` = 0. Then go to READ, or to RESP if the read count is 0.
  - RD_HI / RD_LO: same strobe shape as WR. Capture `bus_data_in` into `rsp_data[8*i+:8]`. Repeat until the read count is reached, then go to RESP.
  - RESP: `rsp_valid` = 1 until `rsp_ready`, then IDLE.
- `bus_wr` and `bus_rd` are never high together. Both are low in IDLE, WAIT_* and RESP.
- During read, bit 7 is data, not BUSY.
- `rsp_data` is cleared on accept.

## Timing
- All bus outputs are registered. `bus_data_out` changes only in the cycle `bus_wr` rises and stays stable until the next rising WR.
- The accelerator detects a strobe edge one cycle after it rises, so strobe low time must be at least 1 cycle. With `STROBE_CYCLES` = 1 the pattern is 1 high, 1 low.
- Read capture: if RD is driven high by edge E0, the host samples `bus_data_in` at edge E0+2. That is the only cycle the byte is valid; the accelerator drives 0x00 afterwards.
- `STROBE_CYCLES` must be at least 2 for read capture to land inside RD_HI/RD_LO. With 1, capture happens in the following RD_LO extension.
- WAIT_BUSY_HI exists because BUSY first appears 2 cycles after the command edge. For CLEAR, BUSY is high for only about 2 cycles; sample every cycle.
- Accept to first `bus_wr` high: 1 cycle. RESP to IDLE: 1 cycle after the `rsp_ready` handshake. Back-to-back requests are allowed from IDLE.

## Configuration
- `HERALD_HOST_TIMEOUT_EN` defined:
  - WAIT_BUSY_HI and WAIT_DONE each count cycles.
  - When the count reaches `TIMEOUT_CYCLES`, strobes go low, FSM goes to RESP with `rsp_err` = 1, `rsp_len` = bytes read so far (0), and `rsp_data` = 0.
  - The counter resets on each wait entry.
- Undefined: no counter logic; waits are unbounded and `rsp_err` is set only for unknown commands.

## Test plan
- MULTIPLY, a=0x001000, b=0x002000, responder model returns 0x002000 -> bus writes 20,00,10,00,00,20,00 in order; 3 RD strobes; `rsp_data` = 0x002000, `rsp_len` = 3, `rsp_err` = 0.
- SINCOS, a=0x000C91, model returns 48'h000FFF_000001 -> 4 writes; 6 reads; `rsp_data[47:0]` matches; upper bytes 0; `rsp_len` = 6.
- NORMALIZE, model returns 72'h0123456789ABCDEF11 with bit 7 set in several bytes -> 7 writes; 9 reads assembled LSB first; no byte mistaken for BUSY.
- CLEAR -> 1 write, no RD strobe, `rsp_len` = 0, `rsp_err` = 0; next MAC request accepted immediately.
- req_cmd = 0x55 -> no strobe toggles; `rsp_valid` with `rsp_err` = 1 two cycles after accept.
- With `HERALD_HOST_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, BUSY stuck at 1 -> `rsp_err` after 16 WAIT_DONE cycles.
- Separately, assert `rst_n` low mid-read -> all outputs 0 asynchronously, `req_ready` = 1 after release.
